// File: rtl/rv_axi_pkg.sv
// -----------------------------------------------------------------------------
// rv_axi_pkg
// Shared types and constants for the two-requester AXI4 read arbiter:
//   - ar_state_e   : AR issue state machine encoding (AR_IDLE / AR_ISSUE)
//   - BURST_* / RESP_* : AXI burst and response codes
//   - OUTST_CNT_W  : width of the per-requester outstanding-burst counters
//   - rr_pick()    : two-way round-robin selection helper
// -----------------------------------------------------------------------------
package rv_axi_pkg;

  typedef enum logic [0:0] {
    AR_IDLE  = 1'b0,
    AR_ISSUE = 1'b1
  } ar_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int OUTST_CNT_W = 4;

  // One-hot pick of the eligible requester at or after the pointer.
  function automatic logic [1:0] rr_pick(input logic [1:0] eligible, input logic ptr);
    logic [1:0] pick;
    pick = 2'b00;
    if (ptr == 1'b0) begin
      if (eligible[0]) pick = 2'b01;
      else if (eligible[1]) pick = 2'b10;
      else pick = 2'b00;
    end else begin
      if (eligible[1]) pick = 2'b10;
      else if (eligible[0]) pick = 2'b01;
      else pick = 2'b00;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rv_axi_rd_arbiter_outst.sv
// -----------------------------------------------------------------------------
// rv_outst_counter
// Saturating up/down counter of outstanding read bursts for one requester.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : a burst was granted this cycle
//   dec        : the last beat of a burst was accepted this cycle
//   count      : current number of outstanding bursts
//   full       : count has reached MAX_OUTST (no further grants allowed)
// -----------------------------------------------------------------------------
module rv_outst_counter
  import rv_axi_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inc,
  input  logic                   dec,
  output logic [OUTST_CNT_W-1:0] count,
  output logic                   full
);

  localparam logic [OUTST_CNT_W-1:0] MAX_VAL = OUTST_CNT_W'(MAX_OUTST);
  localparam logic [OUTST_CNT_W-1:0] ONE     = OUTST_CNT_W'(1);
  localparam logic [OUTST_CNT_W-1:0] ZERO    = OUTST_CNT_W'(0);

  logic [OUTST_CNT_W-1:0] count_r;

  // Count grants up and completed bursts down; a stray rlast at zero is held at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= ZERO;
    end else if (inc && !dec) begin
      if (count_r != MAX_VAL) count_r <= count_r + ONE;
    end else if (dec && !inc) begin
      if (count_r != ZERO) count_r <= count_r - ONE;
    end
  end

  assign count = count_r;
  assign full  = (count_r >= MAX_VAL);

endmodule

// File: rtl/rv_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// rv_axi_rd_arbiter
// Shares one AXI4 master read path between requester 0 (core memory port)
// and requester 1 (host debug/loader). AR requests are granted round-robin,
// registered into a single output slice and tagged with the requester index
// in the ID MSB; R beats are steered back combinationally by that MSB.
// Ports:
//   m_axi_aclk, m_axi_aresetn : clock, asynchronous active-low reset
//   s_ar* / s_r*              : packed per-requester AR and shared R channels
//   m_axi_ar* / m_axi_r*      : master AR and R channels
// Optional: define RV_AXI_RD_ARB_PERF_EN to add perf_grant0/1 and
// perf_beats0/1 (32-bit wrapping grant and R-beat counters).
// -----------------------------------------------------------------------------
module rv_axi_rd_arbiter
  import rv_axi_pkg::*;
#(
  parameter int M_ID_WIDTH = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_OUTST  = 4
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_aresetn,
  input  logic [1:0]                    s_arvalid,
  output logic [1:0]                    s_arready,
  input  logic [2*(M_ID_WIDTH-1)-1:0]   s_arid,
  input  logic [2*ADDR_WIDTH-1:0]       s_araddr,
  input  logic [15:0]                   s_arlen,
  input  logic [5:0]                    s_arsize,
  input  logic [3:0]                    s_arburst,
  output logic [1:0]                    s_rvalid,
  input  logic [1:0]                    s_rready,
  output logic [M_ID_WIDTH-2:0]         s_rid,
  output logic [DATA_WIDTH-1:0]         s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rlast,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [M_ID_WIDTH-1:0]         m_axi_arid,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [M_ID_WIDTH-1:0]         m_axi_rid,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast
`ifdef RV_AXI_RD_ARB_PERF_EN
  ,
  output logic [31:0]                   perf_grant0,
  output logic [31:0]                   perf_grant1,
  output logic [31:0]                   perf_beats0,
  output logic [31:0]                   perf_beats1
`endif
);

  localparam int SID_W = M_ID_WIDTH - 1;

  ar_state_e              state_r;
  logic                   ptr_r;
  logic [M_ID_WIDTH-1:0]  arid_r;
  logic [ADDR_WIDTH-1:0]  araddr_r;
  logic [7:0]             arlen_r;
  logic [2:0]             arsize_r;
  logic [1:0]             arburst_r;

  logic [1:0]             full_s;
  logic [1:0]             eligible_s;
  logic [1:0]             grant_s;
  logic                   gnt_idx_s;
  logic [1:0]             dec_s;
  logic                   sel_s;
  logic                   r_hs_s;
  logic [OUTST_CNT_W-1:0] cnt0_s;
  logic [OUTST_CNT_W-1:0] cnt1_s;

  assign eligible_s = s_arvalid & ~full_s;

  // Grants are only made from IDLE, so at most one burst is in the output slice.
  always_comb begin
    grant_s = 2'b00;
    if (state_r == AR_IDLE) grant_s = rr_pick(eligible_s, ptr_r);
    else grant_s = 2'b00;
  end

  assign gnt_idx_s = grant_s[1];
  assign s_arready = grant_s;

  // AR slice: capture the winner's payload on grant, release on master handshake.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_r   <= AR_IDLE;
      ptr_r     <= 1'b0;
      arid_r    <= '0;
      araddr_r  <= '0;
      arlen_r   <= 8'd0;
      arsize_r  <= 3'd0;
      arburst_r <= 2'b00;
    end else begin
      case (state_r)
        AR_IDLE: begin
          if (grant_s != 2'b00) begin
            state_r   <= AR_ISSUE;
            arid_r    <= {gnt_idx_s, (gnt_idx_s ? s_arid[2*SID_W-1:SID_W] : s_arid[SID_W-1:0])};
            araddr_r  <= gnt_idx_s ? s_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_araddr[ADDR_WIDTH-1:0];
            arlen_r   <= gnt_idx_s ? s_arlen[15:8]   : s_arlen[7:0];
            arsize_r  <= gnt_idx_s ? s_arsize[5:3]   : s_arsize[2:0];
            arburst_r <= gnt_idx_s ? s_arburst[3:2]  : s_arburst[1:0];
          end
        end
        AR_ISSUE: begin
          if (m_axi_arready) begin
            state_r <= AR_IDLE;
            // The ID MSB is the granted index; the other requester is favoured next.
            ptr_r   <= ~arid_r[M_ID_WIDTH-1];
          end
        end
        default: state_r <= AR_IDLE;
      endcase
    end
  end

  assign m_axi_arvalid = (state_r == AR_ISSUE);
  assign m_axi_arid    = arid_r;
  assign m_axi_araddr  = araddr_r;
  assign m_axi_arlen   = arlen_r;
  assign m_axi_arsize  = arsize_r;
  assign m_axi_arburst = arburst_r;

  // R steering: the ID MSB names the requester that owns the beat.
  assign sel_s        = m_axi_rid[M_ID_WIDTH-1];
  assign s_rvalid     = {m_axi_rvalid & sel_s, m_axi_rvalid & ~sel_s};
  assign m_axi_rready = s_rready[sel_s];
  assign s_rid        = m_axi_rid[M_ID_WIDTH-2:0];
  assign s_rdata      = m_axi_rdata;
  assign s_rresp      = m_axi_rresp;
  assign s_rlast      = m_axi_rlast;

  assign r_hs_s = m_axi_rvalid & m_axi_rready;
  assign dec_s  = {r_hs_s & m_axi_rlast & sel_s, r_hs_s & m_axi_rlast & ~sel_s};

  rv_outst_counter #(.MAX_OUTST(MAX_OUTST)) u_outst0 (
    .clk   (m_axi_aclk),
    .rst_n (m_axi_aresetn),
    .inc   (grant_s[0]),
    .dec   (dec_s[0]),
    .count (cnt0_s),
    .full  (full_s[0])
  );

  rv_outst_counter #(.MAX_OUTST(MAX_OUTST)) u_outst1 (
    .clk   (m_axi_aclk),
    .rst_n (m_axi_aresetn),
    .inc   (grant_s[1]),
    .dec   (dec_s[1]),
    .count (cnt1_s),
    .full  (full_s[1])
  );

`ifdef RV_AXI_RD_ARB_PERF_EN
  logic [31:0] perf_grant0_r;
  logic [31:0] perf_grant1_r;
  logic [31:0] perf_beats0_r;
  logic [31:0] perf_beats1_r;

  // Free-running wrapping event counters for grants and accepted R beats.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      perf_grant0_r <= 32'd0;
      perf_grant1_r <= 32'd0;
      perf_beats0_r <= 32'd0;
      perf_beats1_r <= 32'd0;
    end else begin
      if (grant_s[0]) perf_grant0_r <= perf_grant0_r + 32'd1;
      if (grant_s[1]) perf_grant1_r <= perf_grant1_r + 32'd1;
      if (r_hs_s && !sel_s) perf_beats0_r <= perf_beats0_r + 32'd1;
      if (r_hs_s && sel_s) perf_beats1_r <= perf_beats1_r + 32'd1;
    end
  end

  assign perf_grant0 = perf_grant0_r;
  assign perf_grant1 = perf_grant1_r;
  assign perf_beats0 = perf_beats0_r;
  assign perf_beats1 = perf_beats1_r;
`endif

endmodule
